multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 153 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle control unit: IF/ID/EX/MEM/WB sequencer with combinational strobe
// decode, illegal-opcode trap and a retired-instruction counter.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic             PCSrc,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             MemToReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             loadPC,
    output logic [3:0]       ALUCtrl,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SRL = 4'b1000;
    localparam logic [3:0] ALU_SLL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_XOR = 4'b1101;

    state_t cur, nxt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       f7b;
    logic       is_r, is_i, is_lw, is_sw, is_beq, is_legal;
    logic [3:0] alu_dec;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign f7b      = instr[30];
    assign is_r     = (opcode == 7'b0110011);
    assign is_i     = (opcode == 7'b0010011);
    assign is_lw    = (opcode == 7'b0000011);
    assign is_sw    = (opcode == 7'b0100011);
    assign is_beq   = (opcode == 7'b1100011);
    assign is_legal = is_r | is_i | is_lw | is_sw | is_beq;

    always_comb begin
        alu_dec = ALU_ADD;
        if (is_beq) begin
            alu_dec = ALU_SUB;
        end else if (is_r || is_i) begin
            unique case (funct3)
                3'b000:  alu_dec = (is_r && f7b) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_dec = ALU_AND;
                3'b110:  alu_dec = ALU_OR;
                3'b100:  alu_dec = ALU_XOR;
                3'b010:  alu_dec = ALU_SLT;
                3'b001:  alu_dec = ALU_SLL;
                3'b101:  alu_dec = f7b ? ALU_SRA : ALU_SRL;
                default: alu_dec = ALU_ADD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cur <= S_IF;
        else     cur <= nxt;
    end

    always_comb begin
        nxt      = cur;
        PCSrc    = 1'b0;
        ALUSrc   = 1'b0;
        RegWrite = 1'b0;
        MemToReg = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        loadPC   = 1'b0;
        illegal  = 1'b0;
        ALUCtrl  = ALU_ADD;
        if (cur != S_IF) begin
            ALUCtrl = alu_dec;
            ALUSrc  = is_i | is_lw | is_sw;
        end
        unique case (cur)
            S_IF: nxt = S_ID;
            S_ID: begin
                if (is_legal) begin
                    nxt = S_EX;
                end else begin
                    illegal = 1'b1;
                    loadPC  = 1'b1;
                    nxt     = S_IF;
                end
            end
            S_EX: begin
                if (is_r || is_i)        nxt = S_WB;
                else if (is_lw || is_sw) nxt = S_MEM;
                else begin
                    loadPC = is_beq;
                    PCSrc  = is_beq & zero;
                    nxt    = S_IF;
                end
            end
            S_MEM: begin
                if (is_lw) begin
                    MemRead = 1'b1;
                    nxt     = S_WB;
                end else begin
                    MemWrite = is_sw;
                    loadPC   = is_sw;
                    nxt      = S_IF;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                loadPC   = 1'b1;
                MemToReg = is_lw;
                nxt      = S_IF;
            end
            default: nxt = S_IF;
        endcase
        // A reset edge aborts the in-flight instruction, so nothing may commit on it.
        if (rst) begin
            PCSrc    = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            loadPC   = 1'b0;
            illegal  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                    instret <= '0;
        else if (loadPC && !illegal) instret <= instret + CNT_W'(1);
    end

    assign state = cur;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected control vectors are
// queued when an instruction is applied and compared on each falling edge.
module tb_multicycle_ctrl;

    logic        clk, rst, zero;
    logic [31:0] instr;
    logic        PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC, illegal;
    logic [3:0]  ALUCtrl;
    logic [2:0]  state;
    logic [31:0] instret;
    logic        s_PCSrc, s_ALUSrc, s_RegWrite, s_MemToReg, s_MemRead, s_MemWrite, s_loadPC, s_illegal;
    logic [3:0]  s_ALUCtrl;
    logic [2:0]  s_state;
    logic [1:0]  s_instret;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .PCSrc(PCSrc), .ALUSrc(ALUSrc), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .loadPC(loadPC), .ALUCtrl(ALUCtrl),
        .state(state), .illegal(illegal), .instret(instret)
    );

    // Narrow counter instance to exercise wrap-around quickly.
    multicycle_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero),
        .PCSrc(s_PCSrc), .ALUSrc(s_ALUSrc), .RegWrite(s_RegWrite), .MemToReg(s_MemToReg),
        .MemRead(s_MemRead), .MemWrite(s_MemWrite), .loadPC(s_loadPC), .ALUCtrl(s_ALUCtrl),
        .state(s_state), .illegal(s_illegal), .instret(s_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BEQ, K_ILL} kind_t;
    typedef struct {
        logic [14:0] v;
        logic [14:0] m;
    } exp_t;

    localparam logic [14:0] FULL     = 15'h7FFF;
    localparam logic [14:0] M_ALUSRC = 15'h0400;
    localparam logic [14:0] M_ALU    = 15'h000F;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned exp_instret = 0;

    function automatic logic [14:0] pk(input logic [2:0] st, input logic pcs, input logic as,
                                       input logic rw, input logic m2r, input logic mr,
                                       input logic mw, input logic lpc, input logic ill,
                                       input logic [3:0] a);
        return {st, pcs, as, rw, m2r, mr, mw, lpc, ill, a};
    endfunction

    function automatic logic [14:0] observed();
        return {state, PCSrc, ALUSrc, RegWrite, MemToReg, MemRead, MemWrite, loadPC, illegal, ALUCtrl};
    endfunction

    // Entered just after a rising edge with the DUT in IF; leaves it the same way.
    task automatic run(input string name, input logic [31:0] ins, input logic z,
                       input kind_t k, input logic [3:0] alu);
        logic        as, ill, lw, sw, beq;
        exp_t        e;
        logic [14:0] obs;
        int          n;
        as  = (k == K_I) || (k == K_LW) || (k == K_SW);
        ill = (k == K_ILL);
        lw  = (k == K_LW);
        sw  = (k == K_SW);
        beq = (k == K_BEQ);
        instr = ins;
        zero  = z;
        q.push_back('{pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010), FULL & ~M_ALUSRC});
        q.push_back('{pk(3'd1, 0, as, 0, 0, 0, 0, ill, ill, alu),
                      FULL & ~M_ALUSRC & (ill ? ~M_ALU : FULL)});
        if (!ill)
            q.push_back('{pk(3'd2, beq & z, as, 0, 0, 0, 0, beq, 0, alu), FULL});
        if (lw || sw)
            q.push_back('{pk(3'd3, 0, as, 0, 0, lw, sw, sw, 0, alu), FULL});
        if (!ill && !beq && !sw)
            q.push_back('{pk(3'd4, 0, as, 1, lw, 0, 0, 1, 0, alu), FULL});
        n = q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            e   = q.pop_front();
            obs = observed();
            checks++;
            if (((obs ^ e.v) & e.m) != 0) begin
                errors++;
                $display("FAIL %s cyc%0d: got %h expected %h (mask %h)", name, i, obs, e.v, e.m);
            end
            @(posedge clk);
            #1;
        end
        if (!ill) exp_instret++;
        checks++;
        if (instret !== exp_instret) begin
            errors++;
            $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
        end
        checks++;
        if (s_instret !== exp_instret[1:0]) begin
            errors++;
            $display("FAIL %s instret_w2: got %0d expected %0d", name, s_instret, exp_instret[1:0]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; instr = 32'h002081B3; zero = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({state, instret, observed()} !== {3'd0, 32'd0, pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010)}) begin
            errors++;
            $display("FAIL reset: got state %0d instret %0d vec %h expected 0 0 %h",
                     state, instret, observed(), pk(3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0010));
        end
        @(posedge clk);
        #1 rst = 1'b0;
        exp_instret = 0;
    endtask

    task automatic test_rtype();
        run("add", 32'h002081B3, 0, K_R, 4'b0010);
        run("sub", 32'h402081B3, 0, K_R, 4'b0110);
        run("xor", 32'h0020C1B3, 0, K_R, 4'b1101);
        run("or",  32'h0020E1B3, 0, K_R, 4'b0001);
        run("and", 32'h0020F1B3, 0, K_R, 4'b0000);
        run("slt", 32'h0020A1B3, 0, K_R, 4'b0111);
        run("sll", 32'h002091B3, 0, K_R, 4'b1001);
        run("srl", 32'h0020D1B3, 0, K_R, 4'b1000);
        run("sra", 32'h4020D1B3, 0, K_R, 4'b1010);
    endtask

    task automatic test_itype();
        run("addi_f7b", 32'h40008093, 0, K_I, 4'b0010);
        run("srai",     32'h4010D093, 0, K_I, 4'b1010);
    endtask

    task automatic test_mem();
        run("lw", 32'h0000A283, 0, K_LW, 4'b0010);
        run("sw", 32'h0050A223, 1, K_SW, 4'b0010);
    endtask

    task automatic test_beq();
        run("beq_taken",    32'h00000463, 1, K_BEQ, 4'b0110);
        run("beq_nottaken", 32'h00000463, 0, K_BEQ, 4'b0110);
    endtask

    task automatic test_illegal();
        run("illegal", 32'hFFFFFFFF, 0, K_ILL, 4'b0000);
    endtask

    task automatic test_back_to_back();
        logic [31:0] tin[6]  = '{32'h0000A283, 32'h00000463, 32'h0050A223,
                                 32'h0000007F, 32'h402081B3, 32'h0000A283};
        kind_t       tk[6]   = '{K_LW, K_BEQ, K_SW, K_ILL, K_R, K_LW};
        logic [3:0]  ta[6]   = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0110, 4'b0010};
        for (int i = 0; i < 6; i++)
            run("b2b", tin[i], i[0], tk[i], ta[i]);
    endtask

    task automatic test_reset_mid();
        instr = 32'h0050A223; zero = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({state, MemWrite, loadPC, RegWrite, MemRead} !== {3'd3, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_mem: got state %0d mw %b lpc %b rw %b mr %b expected 3 0 0 0 0",
                     state, MemWrite, loadPC, RegWrite, MemRead);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({state, instret, s_instret} !== {3'd0, 32'd0, 2'd0}) begin
            errors++;
            $display("FAIL reset_mid_after: got state %0d instret %0d/%0d expected 0 0/0",
                     state, instret, s_instret);
        end
        rst = 1'b0;
        exp_instret = 0;
        run("post_reset_add", 32'h002081B3, 0, K_R, 4'b0010);
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_mem();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end

endmodule
